jk_bank_arbiter: RTL and testbench
==================================

# jk_bank_arbiter

Shared bank of WIDTH clocked JK flip-flops with two requesters arbitrated round-robin. Each granted requester applies a per-bit JK command (hold / reset / set / toggle) to the bank in one clock. A requester may lock the bank for a multi-cycle sequence, with an idle-timeout release. The block sits between the control FSMs and the latch/flip-flop datapath they configure.

## Interface
Parameters:
- WIDTH, 8, number of JK bits in the bank (≥1)
- MAX_HOLD, 4, idle cycles a locking owner may hold the bank without requesting before forced release (≥1)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- req0  in  1  requester 0 wants a transfer this cycle
- lock0  in  1  requester 0 keeps ownership after this transfer
- j0  in  WIDTH  requester 0 J vector
- k0  in  WIDTH  requester 0 K vector
- gnt0  out  1  combinational grant to requester 0
- req1, lock1, j1, k1, gnt1: same as above for requester 1
- q  out  WIDTH  registered bank state
- owner  out  2  registered: 00 idle, 01 owned by 0, 10 owned by 1
- op_cnt  out  16  registered count of completed transfers, wraps

## Operation
- States: IDLE, OWN0, OWN1; `owner` encodes state directly.
- Transfer on requester i: rising edge with req_i & gnt_i & !reset.
- Bank update per bit on transfer: q <= (~k_i & q) ^ (j_i & ~q). j=0,k=0 hold; j=0,k=1 clear; j=1,k=0 set; j=1,k=1 toggle. No transfer means q holds.
- Grants are combinational from state, last-served pointer `last`, and req inputs. gnt0 and gnt1 are never both high.
  - IDLE: single request granted. If both request, grant goes to the requester ≠ last.
  - OWN_i: only gnt_i possible (gnt_i = req_i); the other requester is never granted.
- On transfer by i: last <= i; op_cnt <= op_cnt + 1 (mod 2^16); hold_cnt <= 0.
  - Next state OWN_i if lock_i = 1 at that edge, else IDLE.
  - lock_i is sampled only on transfer edges.
- Idle-timeout in OWN_i: each edge with req_i = 0 increments hold_cnt. The edge on which the increment would reach MAX_HOLD forces state to IDLE and clears hold_cnt. Result: IDLE after exactly MAX_HOLD consecutive idle edges.
- Internal hold_cnt width: clog2(MAX_HOLD+1); invisible at ports.
- reset: q = 0, owner = 00 (IDLE), last = 1 (requester 0 wins the first tie), op_cnt = 0, hold_cnt = 0. gnt outputs follow the reset-state equations; any coincident req is not a transfer (reset has priority, q stays 0).

## Timing
- Grant latency 0: gnt_i valid in the same cycle as req_i, as a function of registered state.
- Update latency 1: q, op_cnt, owner reflect a transfer immediately after the transfer edge.
- Requester must hold req_i, j_i, k_i, lock_i stable until it samples gnt_i high. Deasserting req without a grant is allowed and has no effect.
- Back-to-back transfers by the same or alternating requesters are allowed every cycle; max throughput is 1 transfer/cycle.
- Lock-release edge (lock_i = 0 transfer) returns to IDLE. The other requester can be granted in the very next cycle.
- Timeout release edge performs no transfer. IDLE arbitration applies the following cycle.

## Test plan
- After reset, check q=0x00, owner=00, op_cnt=0. Then req0, j0=0xF0, k0=0x00 -> gnt0 high the same cycle; after the edge q=0xF0, op_cnt=1, owner=00.
- From q=0xF0: req1 j1=0xFF k1=0xFF -> q=0x0F. Then j1=0x00 k1=0x0F -> q=0x00. Then j1=0x00 k1=0x00 -> q=0x00 unchanged, op_cnt still increments.
- Immediately after reset, req0 and req1 held high for 4 cycles -> grants in order gnt0, gnt1, gnt0, gnt1; op_cnt=4.
- req0+lock0 -> owner=01. req1 held 3 cycles -> gnt1 low throughout while req0 transfers. Then req0 with lock0=0 -> owner=00, and gnt1 high on the next cycle.
- MAX_HOLD=4: lock by req1, then req1 low -> owner=10 for 3 edges, 00 after the 4th. Pending req0 granted the next cycle.
- Reset asserted while owner=01 and req0 high -> no transfer, q=0, owner=00, op_cnt=0. Separately, preload via 0xFFFF transfers, then one more transfer -> op_cnt=0x0000.

Source files
------------

// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: WIDTH-bit bank of JK flip-flops shared by two requesters.
// Requesters are arbitrated round-robin. A requester may lock the bank across
// several transfers, and an owner that stops requesting for MAX_HOLD edges is
// released automatically.
module jk_bank_arbiter #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             lock0,
  input  logic [WIDTH-1:0] j0,
  input  logic [WIDTH-1:0] k0,
  output logic             gnt0,
  input  logic             req1,
  input  logic             lock1,
  input  logic [WIDTH-1:0] j1,
  input  logic [WIDTH-1:0] k1,
  output logic             gnt1,
  output logic [WIDTH-1:0] q,
  output logic [1:0]       owner,
  output logic [15:0]      op_cnt
);

  localparam int HW = $clog2(MAX_HOLD + 1);

  // The encoding doubles as the owner output.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic [HW-1:0]    holdCnt_q, holdCnt_d;
  logic [WIDTH-1:0] bank_q, bank_d;
  logic [15:0]      opCnt_q, opCnt_d;

  // State register: reset wins over any coincident request, so a reset edge
  // never counts as a transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      holdCnt_q <= '0;
      bank_q    <= '0;
      opCnt_q   <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      holdCnt_q <= holdCnt_d;
      bank_q    <= bank_d;
      opCnt_q   <= opCnt_d;
    end
  end

  // Next state: apply the granted JK command, or advance the idle timeout of a
  // locking owner that is not currently requesting.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    holdCnt_d = holdCnt_q;
    bank_d    = bank_q;
    opCnt_d   = opCnt_q;
    if (gnt0) begin
      bank_d    = (~k0 & bank_q) ^ (j0 & ~bank_q);
      last_d    = 1'b0;
      opCnt_d   = opCnt_q + 16'd1;
      holdCnt_d = '0;
      state_d   = lock0 ? OWN0 : IDLE;
    end else if (gnt1) begin
      bank_d    = (~k1 & bank_q) ^ (j1 & ~bank_q);
      last_d    = 1'b1;
      opCnt_d   = opCnt_q + 16'd1;
      holdCnt_d = '0;
      state_d   = lock1 ? OWN1 : IDLE;
    end else if (state_q != IDLE) begin
      if (holdCnt_q == HW'(MAX_HOLD - 1)) begin
        state_d   = IDLE;
        holdCnt_d = '0;
      end else begin
        holdCnt_d = holdCnt_q + HW'(1);
      end
    end
  end

  // Grants: round-robin tie break while idle, exclusive to the owner otherwise.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (state_q)
      IDLE: begin
        gnt0 = req0 & (~req1 | last_q);
        gnt1 = req1 & (~req0 | ~last_q);
      end
      OWN0:    gnt0 = req0;
      OWN1:    gnt1 = req1;
      default: ;
    endcase
  end

  assign q      = bank_q;
  assign owner  = state_q;
  assign op_cnt = opCnt_q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Testbench for jk_bank_arbiter: a behavioural model predicts grants and the
// post-edge state for each issued cycle and queues the prediction; a monitor
// process pops the predictions and compares them against the DUT.
module tb_jk_bank_arbiter;

  localparam int WIDTH    = 8;
  localparam int MAX_HOLD = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             req0 = 1'b0, lock0 = 1'b0, req1 = 1'b0, lock1 = 1'b0;
  logic [WIDTH-1:0] j0 = '0, k0 = '0, j1 = '0, k1 = '0;
  logic             gnt0, gnt1;
  logic [WIDTH-1:0] q;
  logic [1:0]       owner;
  logic [15:0]      op_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic             g0;
    logic             g1;
    logic [WIDTH-1:0] bank;
    logic [1:0]       own;
    logic [15:0]      op;
  } exp_t;

  exp_t sbQ[$];

  // Reference model state: owner 0 = idle, 1 = requester 0, 2 = requester 1.
  int               mOwner = 0;
  int               mLast  = 1;
  int               mIdle  = 0;
  int               mOp    = 0;
  logic [WIDTH-1:0] mBank  = '0;

  jk_bank_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .lock0(lock0), .j0(j0), .k0(k0), .gnt0(gnt0),
    .req1(req1), .lock1(lock1), .j1(j1), .k1(k1), .gnt1(gnt1),
    .q(q), .owner(owner), .op_cnt(op_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] applyJk(input logic [WIDTH-1:0] cur,
                                               input logic [WIDTH-1:0] jv,
                                               input logic [WIDTH-1:0] kv);
    logic [WIDTH-1:0] nxt;
    nxt = cur;
    for (int b = 0; b < WIDTH; b++) begin
      case ({jv[b], kv[b]})
        2'b01:   nxt[b] = 1'b0;
        2'b10:   nxt[b] = 1'b1;
        2'b11:   nxt[b] = ~cur[b];
        default: nxt[b] = cur[b];
      endcase
    end
    return nxt;
  endfunction

  // Drive one cycle of inputs at the falling edge, predict its outcome and
  // queue the prediction for the monitor.
  task automatic applyStimulus(input logic rst,
                               input logic r0, input logic l0,
                               input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0,
                               input logic r1, input logic l1,
                               input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1);
    int   winner;
    exp_t e;
    @(negedge clk);
    reset = rst;
    req0 = r0; lock0 = l0; j0 = a0; k0 = b0;
    req1 = r1; lock1 = l1; j1 = a1; k1 = b1;

    winner = -1;
    if (mOwner == 0) begin
      if (r0 && r1)  winner = (mLast == 0) ? 1 : 0;
      else if (r0)   winner = 0;
      else if (r1)   winner = 1;
    end else if (mOwner == 1) begin
      if (r0) winner = 0;
    end else begin
      if (r1) winner = 1;
    end
    e.g0 = (winner == 0);
    e.g1 = (winner == 1);

    if (rst) begin
      mOwner = 0; mLast = 1; mIdle = 0; mOp = 0; mBank = '0;
    end else if (winner == 0) begin
      mBank  = applyJk(mBank, a0, b0);
      mLast  = 0;
      mOp    = (mOp + 1) % 65536;
      mIdle  = 0;
      mOwner = l0 ? 1 : 0;
    end else if (winner == 1) begin
      mBank  = applyJk(mBank, a1, b1);
      mLast  = 1;
      mOp    = (mOp + 1) % 65536;
      mIdle  = 0;
      mOwner = l1 ? 2 : 0;
    end else if (mOwner != 0) begin
      mIdle++;
      if (mIdle == MAX_HOLD) begin
        mOwner = 0;
        mIdle  = 0;
      end
    end
    e.bank = mBank;
    e.own  = 2'(mOwner);
    e.op   = 16'(mOp);
    sbQ.push_back(e);
  endtask

  task automatic idleCycle(input logic rst);
    applyStimulus(rst, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  // Monitor: grants are checked mid-cycle, registered outputs just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sbQ.size() != 0) begin
        e = sbQ.pop_front();
        checkOutput("gnt0", 32'(gnt0), 32'(e.g0));
        checkOutput("gnt1", 32'(gnt1), 32'(e.g1));
        checkOutput("gntExclusive", 32'(gnt0 & gnt1), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("q", 32'(q), 32'(e.bank));
        checkOutput("owner", 32'(owner), 32'(e.own));
        checkOutput("op_cnt", 32'(op_cnt), 32'(e.op));
      end
    end
  end

  initial begin
    int waitCycles;
    repeat (2) @(posedge clk);

    // Reset state and a first set transfer from requester 0.
    idleCycle(1'b1);
    idleCycle(1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'hF0, 8'h00, 1'b0, 1'b0, '0, '0);
    // Toggle, clear-low-nibble, hold from requester 1.
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 8'hFF, 8'hFF);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 8'h00, 8'h0F);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 8'h00, 8'h00);

    // Round-robin ties straight out of reset.
    idleCycle(1'b1);
    repeat (4) applyStimulus(1'b0, 1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 8'h02, 8'h00);

    // Lock by requester 0 starves requester 1 until released.
    idleCycle(1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h0F, 8'h00, 1'b0, 1'b0, '0, '0);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b1, 8'h11, 8'h11, 1'b1, 1'b0, 8'hAA, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'hAA, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 8'hAA, 8'h00);

    // Idle timeout of a requester 1 lock while requester 0 waits.
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 8'h00, 8'hFF);
    repeat (MAX_HOLD) applyStimulus(1'b0, 1'b1, 1'b0, 8'h3C, 8'h00, 1'b0, 1'b0, '0, '0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h3C, 8'h00, 1'b0, 1'b0, '0, '0);

    // Reset while requester 0 owns the bank and keeps requesting.
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b0, '0, '0);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b0, '0, '0);
    idleCycle(1'b0);

    // Transfer counter wrap.
    for (int n = 0; n < 65536; n++)
      applyStimulus(1'b0, n[0], 1'b0, 8'($urandom), 8'($urandom),
                    ~n[0], 1'b0, 8'($urandom), 8'($urandom));

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++)
      applyStimulus($urandom_range(0, 99) == 0,
                    1'($urandom), $urandom_range(0, 3) == 0, 8'($urandom), 8'($urandom),
                    1'($urandom), $urandom_range(0, 3) == 0, 8'($urandom), 8'($urandom));

    idleCycle(1'b0);
    waitCycles = 0;
    while (sbQ.size() != 0 && waitCycles < 20) begin
      @(posedge clk);
      waitCycles++;
    end
    @(posedge clk);
    #2;
    if (sbQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboardDrain actual=%0d expected=0", sbQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
